// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: two-flop synchronizer, counter debounce, rising-edge pulse.
// Define BUTTON_PRESS_PULSE_EN to build the pressed_o pulse registers; otherwise pressed_o is tied low.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] buttons_raw_i,
    output logic [3:0] buttons_o,
    output logic [3:0] pressed_o
);

    localparam int                 NCH      = 4;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations where the terminal count cannot be represented.
    if (DEBOUNCE_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_cfg_err
        $error("button_conditioner: DEBOUNCE_CYCLES=%0d out of range for CNT_W=%0d",
               DEBOUNCE_CYCLES, CNT_W);
    end

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Counter clears whenever the synchronized level agrees with the accepted level,
    // so only an unbroken run of DEBOUNCE_CYCLES mismatches changes stable.
    always_comb begin
        stable_d = stable_q;
        for (int n = 0; n < NCH; n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != stable_q[n]) begin
                if (cnt_q[n] == CNT_LAST) begin
                    stable_d[n] = sync2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync1_q  <= buttons_raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int n = 0; n < NCH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign buttons_o = stable_q;

`ifdef BUTTON_PRESS_PULSE_EN
    logic [3:0] pressed_q;
    logic [3:0] pressed_d;

    // Pulse is registered on the same edge stable rises, so it occupies the following cycle.
    always_comb begin
        pressed_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end

    assign pressed_o = pressed_q;
`else
    assign pressed_o = 4'b0000;
`endif

endmodule
